// File: rtl/l4_ctrl_unit.sv
// Multicycle fetch/decode/execute/memory control FSM for the Lab 4 16-bit datapath.
// Optional memory-wait timeout (bus error, then HALT) is built when L4_CTRL_TIMEOUT_EN is defined.
module l4_ctrl_unit #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             IRin,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             rf_we,
   output logic             rf_src_sel,
   output logic [3:0]       alu_op,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_NOT   = 4'd6;
   localparam logic [3:0] OP_SHL   = 4'd7;
   localparam logic [3:0] OP_SHR   = 4'd8;
   localparam logic [3:0] OP_LOAD  = 4'd9;
   localparam logic [3:0] OP_STORE = 4'd10;
   localparam logic [3:0] OP_HALT  = 4'd11;
   localparam logic [3:0] OP_JMP   = 4'd12;
   localparam logic [3:0] OP_BZ    = 4'd13;

   localparam logic [3:0] ALU_PASS_A = 4'd0;

   logic [2:0] next_state;
   logic       retire;
   logic       timeout_hit;

   // State register and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_FETCH;
         instr_count <= '0;
      end else begin
         state <= next_state;
         if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

   // Next-state and strobe decode; every strobe stays low while reset is high.
   always_comb begin
      next_state = state;
      IRin       = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      rf_we      = 1'b0;
      rf_src_sel = 1'b0;
      alu_op     = ALU_PASS_A;
      halted     = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;

      if (!reset) begin
         case (state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  IRin       = 1'b1;
                  pc_inc     = 1'b1;
                  next_state = ST_DECODE;
               end else if (timeout_hit) begin
                  next_state = ST_HALT;
               end
            end

            ST_DECODE: begin
               case (opcode)
                  OP_NOP: begin
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR,
                  OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                     next_state = ST_EXEC;
                  end
                  OP_LOAD, OP_STORE: begin
                     next_state = ST_MEM;
                  end
                  OP_JMP: begin
                     pc_load    = 1'b1;
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end
                  OP_BZ: begin
                     // Branch condition comes from src_reg1 passed straight through the ALU.
                     pc_load    = alu_zero;
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end
                  OP_HALT: begin
                     retire     = 1'b1;
                     next_state = ST_HALT;
                  end
                  default: begin
                     illegal_op = 1'b1;
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end
               endcase
            end

            ST_EXEC: begin
               alu_op     = opcode;
               rf_we      = 1'b1;
               retire     = 1'b1;
               next_state = ST_FETCH;
            end

            ST_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (opcode == OP_STORE);
               if (mem_ready) begin
                  rf_we      = (opcode == OP_LOAD);
                  rf_src_sel = (opcode == OP_LOAD);
                  retire     = 1'b1;
                  next_state = ST_FETCH;
               end else if (timeout_hit) begin
                  next_state = ST_HALT;
               end
            end

            ST_HALT: begin
               halted = 1'b1;
            end

            default: begin
               next_state = ST_FETCH;
            end
         endcase
      end
   end

`ifdef L4_CTRL_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WAIT_W-1:0] wait_cnt;
   logic              bus_err_q;
   logic              waiting;

   // Derived from state rather than mem_req to keep the decode loop-free.
   assign waiting     = !reset && !mem_ready && ((state == ST_FETCH) || (state == ST_MEM));
   assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign bus_err     = bus_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (timeout_hit) begin
            bus_err_q <= 1'b1;
         end
         if (next_state != state) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;

   // Timeout depth has no effect when the wait counter is not built.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

endmodule
